// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and address packing for the text console writer.
package text_console_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 60;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {SCREEN_CLR, IDLE, LINE_CLR} state_e;

  // Same {row, col} layout the display pipeline uses on the read port.
  function automatic logic [12:0] pack_addr(input logic [5:0] row, input logic [6:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/text_console_writer_if.sv
// Byte stream into the console writer: character + colour over valid/ready.
interface text_console_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [3:0] in_color;

  modport master (output in_valid, output in_char, output in_color, input in_ready);
  modport slave  (input in_valid, input in_char, input in_color, output in_ready);
endinterface

// File: rtl/text_console_writer_clear_sweep.sv
// Row/col sweep counter shared by the full-screen and single-line clears.
module console_clear_sweep #(
  parameter int COLS = 80,
  parameter int ROWS = 60
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        full_screen,
  input  logic [5:0]  row,
  output logic [12:0] addr,
  output logic        wr,
  output logic        done
);
  import text_console_pkg::pack_addr;

  logic       active, full;
  logic [6:0] col_q;
  logic [5:0] row_q;
  logic       last_col, last_row;

  assign last_col = (col_q == 7'(COLS-1));
  assign last_row = !full || (row_q == 6'(ROWS-1));
  assign wr       = active;
  assign done     = active && last_col && last_row;
  assign addr     = pack_addr(row_q, col_q);

  // Reset leaves the engine armed for a full-screen sweep from cell 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b1;
      full   <= 1'b1;
      col_q  <= '0;
      row_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      full   <= full_screen;
      col_q  <= '0;
      row_q  <= full_screen ? '0 : row;
    end else if (active) begin
      if (last_col) begin
        col_q <= '0;
        if (done) active <= 1'b0;
        else      row_q  <= row_q + 6'd1;
      end else begin
        col_q <= col_q + 7'd1;
      end
    end
  end
endmodule

// File: rtl/text_console_writer.sv
// Cursor-tracking writer for the 80x60 text map RAMs, with line and screen clears.
module text_console_writer #(
  parameter int         COLS        = text_console_pkg::COLS,
  parameter int         ROWS        = text_console_pkg::ROWS,
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter logic [3:0] CLEAR_COLOR = 4'h7
)(
  input  logic                clk,
  input  logic                rst_n,
  text_console_writer_if.slave in_bus,
  output logic                wr_en,
  output logic [12:0]         wr_addr,
  output logic [7:0]          wr_char,
  output logic [3:0]          wr_color,
  output logic [6:0]          cursor_col,
  output logic [5:0]          cursor_row,
  output logic                busy
);
  import text_console_pkg::state_e, text_console_pkg::SCREEN_CLR, text_console_pkg::IDLE,
         text_console_pkg::LINE_CLR, text_console_pkg::CC_BS, text_console_pkg::CC_LF,
         text_console_pkg::CC_FF, text_console_pkg::CC_CR, text_console_pkg::pack_addr;

  state_e      state;
  logic        xfer, col_last, printable;
  logic [5:0]  row_inc;
  logic        sw_start, sw_full, sw_wr, sw_done, sw_fin;
  logic [12:0] sw_addr;

  assign in_bus.in_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign xfer            = in_bus.in_valid && in_bus.in_ready;
  assign col_last        = (cursor_col == 7'(COLS-1));
  assign row_inc         = (cursor_row == 6'(ROWS-1)) ? 6'd0 : cursor_row + 6'd1;
  assign printable       = !(in_bus.in_char inside {CC_BS, CC_LF, CC_FF, CC_CR});
  assign sw_full         = (in_bus.in_char == CC_FF);
  assign sw_start        = xfer && (sw_full || in_bus.in_char == CC_LF || (printable && col_last));

  console_clear_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
    .clk, .rst_n,
    .start(sw_start), .full_screen(sw_full), .row(row_inc),
    .addr(sw_addr), .wr(sw_wr), .done(sw_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SCREEN_CLR;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_char    <= '0;
      wr_color   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      sw_fin     <= 1'b0;
    end else begin
      sw_fin <= sw_done;
      wr_en  <= 1'b0;
      case (state)
        SCREEN_CLR, LINE_CLR: begin
          wr_en    <= sw_wr;
          wr_addr  <= sw_addr;
          wr_char  <= BLANK_CHAR;
          wr_color <= CLEAR_COLOR;
          // Leave one cycle after the last sweep write before accepting bytes.
          if (sw_fin) begin
            state <= IDLE;
            if (state == SCREEN_CLR) begin
              cursor_col <= '0;
              cursor_row <= '0;
            end
          end
        end
        default: if (xfer) begin
          case (in_bus.in_char)
            CC_CR: cursor_col <= '0;
            CC_LF: begin
              cursor_col <= '0;
              cursor_row <= row_inc;
              state      <= LINE_CLR;
            end
            CC_FF: state <= SCREEN_CLR;
            CC_BS: if (cursor_col != 7'd0) begin
              cursor_col <= cursor_col - 7'd1;
              wr_en      <= 1'b1;
              wr_addr    <= pack_addr(cursor_row, cursor_col - 7'd1);
              wr_char    <= BLANK_CHAR;
              wr_color   <= in_bus.in_color;
            end
            default: begin
              wr_en    <= 1'b1;
              wr_addr  <= pack_addr(cursor_row, cursor_col);
              wr_char  <= in_bus.in_char;
              wr_color <= in_bus.in_color;
              if (col_last) begin
                cursor_col <= '0;
                cursor_row <= row_inc;
                state      <= LINE_CLR;
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table plus clear-sweep sequences.
module tb_text_console_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, busy;
  logic [12:0] wr_addr;
  logic [7:0]  wr_char;
  logic [3:0]  wr_color;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  int          n_vec = 0;
  int          n_err = 0;

  text_console_writer_if bus();

  text_console_writer dut (
    .clk(clk), .rst_n(rst_n), .in_bus(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .wr_color(wr_color),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;   logic [3:0] co;
    logic        wr;   logic [12:0] addr;
    logic [7:0]  wch;  logic [3:0]  wco;
    logic [6:0]  col;  logic [5:0]  row;
  } vec_t;
  vec_t vt[11];

  function automatic logic [12:0] A(input int r, input int c);
    return 13'(r * 128 + c);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the transfer's outputs are visible.
  task automatic send(input logic [7:0] c, input logic [3:0] co);
    int t = 0;
    bus.in_valid = 1'b1; bus.in_char = c; bus.in_color = co;
    while (!bus.in_ready && t < 10000) begin @(negedge clk); t++; end
    if (t >= 10000) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Follows one run of consecutive clear writes, checking order and contents.
  task automatic sweep(input string nm, input int exp_n, input logic [12:0] first, input logic [12:0] last);
    int n = 0, t = 0, r, c;
    logic [12:0] fa, la;
    bit bad = 0;
    while (!wr_en && t < 10) begin @(negedge clk); t++; end
    fa = wr_addr; la = wr_addr;
    r = int'(first[12:7]); c = int'(first[6:0]);
    while (wr_en && n < 6000) begin
      la = wr_addr;
      if (wr_addr !== A(r, c) || wr_char !== 8'h20 || wr_color !== 4'h7 || bus.in_ready || !busy) bad = 1;
      c++; if (c == 80) begin c = 0; r++; end
      n++;
      @(negedge clk);
    end
    check({nm, "_count"}, n, exp_n);
    check({nm, "_first"}, fa, first);
    check({nm, "_last"}, la, last);
    check({nm, "_order_data"}, bad, 0);
    check({nm, "_ready_after"}, bus.in_ready, 1);
    check({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_char = '0; bus.in_color = '0;

    vt[0]  = '{8'h41, 4'h4, 1'b1, A(0,0), 8'h41, 4'h4, 7'd1, 6'd0};
    vt[1]  = '{8'h42, 4'h2, 1'b1, A(0,1), 8'h42, 4'h2, 7'd2, 6'd0};
    vt[2]  = '{8'h0D, 4'h1, 1'b0, A(0,0), 8'h00, 4'h0, 7'd0, 6'd0};
    vt[3]  = '{8'h43, 4'h3, 1'b1, A(0,0), 8'h43, 4'h3, 7'd1, 6'd0};
    vt[4]  = '{8'h44, 4'h6, 1'b1, A(0,1), 8'h44, 4'h6, 7'd2, 6'd0};
    vt[5]  = '{8'h45, 4'h1, 1'b1, A(0,2), 8'h45, 4'h1, 7'd3, 6'd0};
    vt[6]  = '{8'h08, 4'h5, 1'b1, A(0,2), 8'h20, 4'h5, 7'd2, 6'd0};
    vt[7]  = '{8'h08, 4'h0, 1'b1, A(0,1), 8'h20, 4'h0, 7'd1, 6'd0};
    vt[8]  = '{8'h08, 4'h7, 1'b1, A(0,0), 8'h20, 4'h7, 7'd0, 6'd0};
    vt[9]  = '{8'h08, 4'h3, 1'b0, A(0,0), 8'h00, 4'h0, 7'd0, 6'd0};
    vt[10] = '{8'h5A, 4'h4, 1'b1, A(0,0), 8'h5A, 4'h4, 7'd1, 6'd0};

    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", {wr_char, wr_color}, 0);
    check("rst_cursor", {cursor_row, cursor_col}, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1;
    sweep("init_clr", 4800, A(0,0), A(59,79));
    check("init_cursor", {cursor_row, cursor_col}, 0);

    // Back-to-back table: one byte per cycle, in_valid held throughout.
    bus.in_valid = 1'b1; bus.in_char = vt[0].ch; bus.in_color = vt[0].co;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_wr_en", i), wr_en, vt[i].wr);
      if (vt[i].wr) begin
        check($sformatf("v%0d_addr", i), wr_addr, vt[i].addr);
        check($sformatf("v%0d_data", i), {wr_char, wr_color}, {vt[i].wch, vt[i].wco});
      end
      check($sformatf("v%0d_cursor", i), {cursor_row, cursor_col}, {vt[i].row, vt[i].col});
      check($sformatf("v%0d_ready", i), bus.in_ready, 1);
      if (i < 10) begin bus.in_char = vt[i+1].ch; bus.in_color = vt[i+1].co; end
      else bus.in_valid = 1'b0;
    end

    // Fill row 0 up to col 79, then wrap with a printable byte.
    bus.in_valid = 1'b1; bus.in_char = 8'h78; bus.in_color = 4'h1;
    repeat (78) @(negedge clk);
    bus.in_valid = 1'b0;
    check("fill_cursor", {cursor_row, cursor_col}, {6'd0, 7'd79});
    send(8'h41, 4'h4);
    check("wrap_wr", {wr_en, wr_addr, wr_char, wr_color}, {1'b1, A(0,79), 8'h41, 4'h4});
    check("wrap_cursor", {cursor_row, cursor_col}, {6'd1, 7'd0});
    check("wrap_busy", {busy, bus.in_ready}, 2'b10);
    @(negedge clk);
    sweep("wrap_clr", 80, A(1,0), A(1,79));

    // Walk down to row 59 with LFs held while the line clears run.
    for (int i = 0; i < 58; i++) send(8'h0A, 4'h0);
    for (int i = 0; i < 5; i++) send(8'h61, 4'h2);
    check("r59_cursor", {cursor_row, cursor_col}, {6'd59, 7'd5});
    send(8'h0A, 4'h3);
    check("lf_nowrite", wr_en, 0);
    check("lf_cursor", {cursor_row, cursor_col}, 0);
    sweep("lf_clr", 80, A(0,0), A(0,79));

    // Reset in the middle of a line clear.
    send(8'h0A, 4'h0);
    repeat (40) @(negedge clk);
    check("mid_addr", {wr_en, wr_addr}, {1'b1, A(1,39)});
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_state", {busy, bus.in_ready, cursor_row, cursor_col}, {2'b10, 13'd0});
    rst_n = 1'b1;
    sweep("rst_clr", 4800, A(0,0), A(59,79));

    // Form feed from a non-home cursor.
    send(8'h51, 4'h2);
    check("ff_pre_cursor", {cursor_row, cursor_col}, {6'd0, 7'd1});
    send(8'h0C, 4'h5);
    check("ff_nowrite", {wr_en, busy}, 2'b01);
    sweep("ff_clr", 4800, A(0,0), A(59,79));
    check("ff_cursor", {cursor_row, cursor_col}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream producer for the 80x60 text-mode display.
- Accepts a byte stream (character code plus 4-bit colour) over a valid/ready handshake.
- Maintains a cursor and writes character and colour into the write port of the dual-port character-map / colour-map RAMs; the display pipeline reads the other port.
- Handles CR, LF, BS and FF, line wrap and row wrap, and clears rows and the screen with a sweeping write engine.

Parameters:
- COLS, 80, visible columns per row.
- ROWS, 60, visible rows.
- BLANK_CHAR, 8'h20, character code written when clearing.
- CLEAR_COLOR, 4'h7, colour written when clearing.

Ports:
- clk  in  1  pixel-domain clock (25 MHz).
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_char/in_color valid.
- in_ready  out  1  block can accept a byte this cycle.
- in_char  in  8  character code or control byte.
- in_color  in  4  colour for this character, bit2=R, bit1=G, bit0=B.
- wr_en  out  1  map RAM write strobe.
- wr_addr  out  13  {row[5:0], col[6:0]}, same layout as the display read address.
- wr_char  out  8  data to character map.
- wr_color  out  4  data to colour map.
- cursor_col  out  7  current column, 0..COLS-1.
- cursor_row  out  6  current row, 0..ROWS-1.
- busy  out  1  clear engine active.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Reset is synchronous, active-low (rst_n); sampled only on the clk rising edge.
- Values while rst_n=0:
  - wr_en=0, wr_addr=0, wr_char=0, wr_color=0.
  - cursor 0/0, in_ready=0, busy=1.
  - FSM state is SCREEN_CLR with the sweep counter at 0.
- Reset mid-operation: aborts any sweep or pending write and restarts the full-screen clear.
- FSM states:
  - SCREEN_CLR: sweeps rows 0..ROWS-1, cols 0..COLS-1, row-major. One write per cycle: wr_en=1, BLANK_CHAR/CLEAR_COLOR. 4800 consecutive writes. Next cycle goes to IDLE with cursor 0/0.
  - IDLE: in_ready=1, busy=0. A transfer occurs when in_valid && in_ready.
  - LINE_CLR: sweeps cols 0..COLS-1 of cursor_row, 80 writes, busy=1, in_ready=0, then returns to IDLE.
- Address rules:
  - Column addresses COLS..127 are never written.
  - wr_addr col field is zero-extended to 7 bits.
- Transfer handling (registered outputs, latency 1 — wr_* and cursor update on the edge that samples the handshake):
  - 0x0D CR: col=0; no write.
  - 0x0A LF: col=0, row=row+1 (ROWS-1 wraps to 0); enter LINE_CLR for the new row; no character write.
  - 0x08 BS: if col>0, col=col-1 and write BLANK_CHAR/in_color at the new position. At col 0: no-op, no write.
  - 0x0C FF: enter SCREEN_CLR; cursor returns to 0/0 when the sweep ends.
  - Any other byte: write in_char/in_color at the cursor, then col+1.
    - At col COLS-1: col=0, row+1 (with wrap) and enter LINE_CLR for the new row.
    - The character write and the transition to LINE_CLR occur on the same edge; the first clear write follows on the next cycle.
- Throughput and timing:
  - In IDLE, back-to-back printable bytes are accepted every cycle.
  - in_ready is driven combinationally from state only, never from in_valid.
  - wr_en is high for exactly one cycle per printable or BS write.
  - in_valid while in_ready=0 is held by the producer; nothing is lost or duplicated.
- Sweep contents: the clear sweeps use BLANK_CHAR/CLEAR_COLOR regardless of in_color.
- Arithmetic: counters are sized to COLS/ROWS limits using compare-and-reset, not power-of-two overflow.

Decomposition:
- Shared package text_console_pkg:
  - Control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - FSM state encoding: SCREEN_CLR, IDLE, LINE_CLR.
  - Geometry constants COLS/ROWS.
  - Address-pack function {row, col}.
- One sub-module: console_clear_sweep.
  - Row/col counter pair; inputs start, full_screen and row.
  - Outputs cell address, wr strobe and done.
  - Reused for both SCREEN_CLR and LINE_CLR.

Test Plan:
- Reset, then release rst_n → exactly 4800 wr_en pulses; the first is addr 0, the last is {6'd59, 7'd79}; all with char 8'h20, color 4'h7. in_ready rises the following cycle, cursor 0/0.
- In IDLE, send 'A'(8'h41)/color 4'h4 then 'B'/4'h2 on back-to-back cycles → writes at addr 0 and addr 1 on consecutive cycles; cursor_col=2, no stalls.
- Cursor at col 79 row 0, send 8'h41 → write at {0,79}; cursor 0/1; busy for 80 cycles writing {1,0}..{1,79} with 8'h20; in_ready=0 throughout, then 1.
- Cursor at row 59 col 5, send LF → no char write; cursor 0/0; row 0 cleared (80 writes).
- Cursor at col 3, send BS → write 8'h20 at col 2, cursor_col=2. Send BS at col 0 → no write, cursor unchanged.
- Mid LINE_CLR (after 40 writes) assert rst_n=0 for one cycle → wr_en=0 during reset; a full 4800-write sweep restarts from addr 0. Send FF in IDLE → 4800-write sweep, cursor 0/0 after.
